exec_issue: RTL
===============

// Module: exec_issue
// PURPOSE
//  Execute-side consumer of the fetch unit's instruction FIFO interface. It pops
//  {addr,instr} packets, executes a one-accumulator mini-ISA, resolves branches
//  (fetch predicts every branch taken) and drives restart on mispredicts. It
//  issues load/store requests back into fetch's shared instruction/data RAM port.
//  Sits directly after fetch; together the two form the whole core.
// PARAMETERS
//  I_WIDTH     13  instruction/data word width
//  A_WIDTH     10  RAM address width
//  O_WIDTH     5   branch offset width (2's complement, instr[O_WIDTH-1:0])
//  RESET_ADDR  0   PC driven on restart after reset
// PORTS
//  clk                  in   1        single clock, rising edge
//  reset_i              in   1        synchronous, active-high
//  instruction_data_i   in   I_WIDTH  FIFO head instruction
//  instruction_addr_i   in   A_WIDTH  FIFO head PC
//  instruction_valid_i  in   1        FIFO head valid
//  dequeue_o            out  1        pop FIFO head (instruction retired)
//  restart_o            out  1        flush FIFO, refetch from restart_addr_o
//  restart_addr_o       out  A_WIDTH  restart PC
//  load_store_valid_o   out  1        memory request strobe (1 cycle)
//  store_en_o           out  1        request is a store
//  load_store_addr_o    out  A_WIDTH  memory address
//  store_data_o         out  I_WIDTH  store data (= accumulator)
//  load_data_i          in   I_WIDTH  load return data
//  load_data_valid_i    in   1        load return strobe
//  acc_o                out  I_WIDTH  architectural accumulator
//  halted_o             out  1        HALT retired
// BEHAVIOUR
//  Encoding: [12]=1 BNZ off=instr[4:0]. [12]=0 class [11:10]: 00 ALU, 01 LOAD,
//   10 STORE, 11 reserved (retire as NOP). ALU sub-op [9:8]: 00 NOP,
//   01 ADDI acc+=sext(instr[7:0]), 10 LDI acc=sext(instr[7:0]), 11 HALT.
//   LOAD/STORE address = instr[9:0].
//  FSM: RESTART -> FLUSH -> ISSUE; ISSUE -> LD_WAIT | RESTART | HALT; LD_WAIT -> ISSUE.
//  Reset: state=RESTART, acc=0, all strobes 0, halted_o=0.
//   The first cycle after reset_i falls drives restart_o=1, restart_addr_o=RESET_ADDR.
//  RESTART (1 cycle): restart_o=1, dequeue_o=0. FLUSH (1 cycle): ignore valid, no dequeue.
//  ISSUE and instruction_valid_i: decode head combinationally.
//   ALU/NOP/reserved: dequeue_o=1 that cycle; acc updates at the edge.
//   BNZ: taken iff acc!=0. Taken: dequeue_o=1 only.
//    Not taken: dequeue_o=0; goto RESTART with addr = instruction_addr_i+1 mod 2^A_WIDTH.
//   STORE: load_store_valid_o=store_en_o=1, store_data_o=acc, dequeue_o=1 same cycle.
//   LOAD: load_store_valid_o=1, store_en_o=0, no dequeue; goto LD_WAIT.
//   HALT: dequeue_o=1, goto HALT; halted_o=1 until reset; all outputs idle.
//  LD_WAIT: waits indefinitely. On load_data_valid_i: acc=load_data_i; dequeue_o=1; goto ISSUE.
//   load_data_valid_i in any other state is ignored.
//  All strobe outputs are combinational from state + head; they are 0 when
//   instruction_valid_i=0. restart_addr_o/load_store_addr_o are 0 when not strobed.
//  Arithmetic: ADDI wraps mod 2^I_WIDTH. Branch sext/adds mod 2^A_WIDTH.
//  Accumulator writes from prior instruction visible to next (1 instr/cycle max).
//  reset_i mid-LD_WAIT aborts the load; a late load_data_valid_i is then ignored.
// STRUCTURE
//  Package exec_pkg: opcode/class/sub-op enums, state enum, field slice constants.
//  Sub-module exec_decode (combinational: instr -> class, sub-op, imm, offset).
//  FSM + accumulator stay in exec_issue.
// TESTING
//  Reset: after release -> restart_o=1 addr 0x000 for 1 cycle, then 1 FLUSH cycle,
//   dequeue_o=0 throughout.
//  LDI 0x0205 then ADDI 0x01FF -> acc_o=0x0005 then 0x0004; dequeue each cycle.
//  acc=0, BNZ 0x1003 @0x3FF -> restart_o=1, restart_addr_o=0x000, no dequeue.
//   acc=1: dequeue only.
//  LOAD 0x0523 -> 1-cycle req addr 0x123 store_en 0; load_data_valid_i 3 cycles later
//   data 0x1ABC -> acc=0x1ABC, dequeue same cycle.
//  acc=0x0AA, STORE 0x0BFF -> valid+store_en, addr 0x3FF, data 0x0AA, dequeue same cycle.
//  HALT 0x0300 -> halted_o=1, no further dequeue.
//   reset_i during LD_WAIT -> RESTART, stale load_data_valid_i ignored.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and field positions for the execute stage.
// Mini-ISA: one accumulator, BNZ / ALU / LOAD / STORE classes.
package exec_pkg;

  localparam int I_WIDTH   = 13;
  localparam int A_WIDTH   = 10;
  localparam int O_WIDTH   = 5;
  localparam int IMM_WIDTH = 8;
  localparam int BNZ_BIT   = 12;
  localparam int CLS_LSB   = 10;
  localparam int OP_LSB    = 8;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOAD  = 2'b01,
    CLS_STORE = 2'b10,
    CLS_RSVD  = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADDI = 2'b01,
    OP_LDI  = 2'b10,
    OP_HALT = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_RESTART,
    ST_FLUSH,
    ST_ISSUE,
    ST_LD_WAIT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic                 bnz;
    cls_e                 cls;
    alu_op_e              op;
    logic [I_WIDTH-1:0]   imm;
    logic [A_WIDTH-1:0]   mem_addr;
  } dec_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational field decode of the FIFO head instruction.
// Produces class, ALU sub-op, sign-extended immediate, memory address.
module exec_decode
  import exec_pkg::*;
(
  input  logic [I_WIDTH-1:0] instr,
  output dec_t               dec
);

  // split the instruction word into its fields
  always_comb begin
    dec.bnz      = instr[BNZ_BIT];
    dec.cls      = cls_e'(instr[CLS_LSB +: 2]);
    dec.op       = alu_op_e'(instr[OP_LSB +: 2]);
    dec.imm      = {{(I_WIDTH-IMM_WIDTH){instr[IMM_WIDTH-1]}},
                    instr[IMM_WIDTH-1:0]};
    dec.mem_addr = instr[A_WIDTH-1:0];
  end

endmodule

// File: rtl/exec_issue.sv
// Execute stage: pops fetch FIFO, runs the accumulator ISA,
// resolves taken-predicted branches and issues RAM requests.
module exec_issue
  import exec_pkg::*;
#(
  parameter logic [A_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [I_WIDTH-1:0] instruction_data_i,
  input  logic [A_WIDTH-1:0] instruction_addr_i,
  input  logic               instruction_valid_i,
  output logic               dequeue_o,
  output logic               restart_o,
  output logic [A_WIDTH-1:0] restart_addr_o,
  output logic               load_store_valid_o,
  output logic               store_en_o,
  output logic [A_WIDTH-1:0] load_store_addr_o,
  output logic [I_WIDTH-1:0] store_data_o,
  input  logic [I_WIDTH-1:0] load_data_i,
  input  logic               load_data_valid_i,
  output logic [I_WIDTH-1:0] acc_o,
  output logic               halted_o
);

  state_e             state, state_nxt;
  logic [I_WIDTH-1:0] acc, acc_nxt;
  logic [A_WIDTH-1:0] rs_addr, rs_addr_nxt;
  dec_t               dec;

  exec_decode u_decode (
    .instr (instruction_data_i),
    .dec   (dec)
  );

  // state, accumulator and pending restart address
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state   <= ST_RESTART;
      acc     <= '0;
      rs_addr <= RESET_ADDR;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      rs_addr <= rs_addr_nxt;
    end
  end

  // next state, accumulator update and strobes
  always_comb begin
    state_nxt          = state;
    acc_nxt            = acc;
    rs_addr_nxt        = rs_addr;
    dequeue_o          = 1'b0;
    restart_o          = 1'b0;
    restart_addr_o     = '0;
    load_store_valid_o = 1'b0;
    store_en_o         = 1'b0;
    load_store_addr_o  = '0;
    store_data_o       = '0;
    if (!reset_i) begin
      unique case (state)
        ST_RESTART: begin
          restart_o      = 1'b1;
          restart_addr_o = rs_addr;
          state_nxt      = ST_FLUSH;
        end
        ST_FLUSH: state_nxt = ST_ISSUE;
        ST_ISSUE: begin
          if (instruction_valid_i) begin
            if (dec.bnz) begin
              if (acc != '0) begin
                dequeue_o = 1'b1;
              end else begin
                state_nxt   = ST_RESTART;
                rs_addr_nxt = instruction_addr_i
                            + A_WIDTH'(1);
              end
            end else begin
              unique case (dec.cls)
                CLS_ALU: begin
                  dequeue_o = 1'b1;
                  unique case (dec.op)
                    OP_NOP:  ;
                    OP_ADDI: acc_nxt = acc + dec.imm;
                    OP_LDI:  acc_nxt = dec.imm;
                    OP_HALT: state_nxt = ST_HALT;
                  endcase
                end
                CLS_LOAD: begin
                  load_store_valid_o = 1'b1;
                  load_store_addr_o  = dec.mem_addr;
                  state_nxt          = ST_LD_WAIT;
                end
                CLS_STORE: begin
                  load_store_valid_o = 1'b1;
                  store_en_o         = 1'b1;
                  load_store_addr_o  = dec.mem_addr;
                  store_data_o       = acc;
                  dequeue_o          = 1'b1;
                end
                CLS_RSVD: dequeue_o = 1'b1;
              endcase
            end
          end
        end
        ST_LD_WAIT: begin
          if (load_data_valid_i) begin
            acc_nxt   = load_data_i;
            dequeue_o = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
        ST_HALT: ;
      endcase
    end
  end

  assign acc_o    = acc;
  assign halted_o = (state == ST_HALT);

endmodule
